sram_arbiter: RTL

//  Shares the single external-SRAM controller port (18-bit addr, 16-bit data) between two requesters:

---
 rtl/sram_arb_pkg.sv | 23 ++
 rtl/sram_arb_pick.sv | 44 ++++
 rtl/sram_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_pkg
// Description : Shared definitions for the two-port SRAM arbiter: FSM state
//               encoding, requester port ids and the abort read-data pattern.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  // Wide enough for any data width; users size-cast it down to DW.
  localparam logic [63:0] RDATA_ABORT = '1;

endpackage
`default_nettype wire

// File: rtl/sram_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_pick
// Description : Combinational grant selection between the CPU port (0) and
//               the auxiliary port (1).
//               Build option SRAM_ARB_RR_EN: round-robin on simultaneous
//               requests (the port not granted last wins); when undefined the
//               CPU port always wins and 'last' is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       gnt_valid
);

`ifndef SRAM_ARB_RR_EN
  // Fixed priority has no use for the history pointer.
  logic unused_last;
  assign unused_last = last;
`endif

  // Pick a winner from the currently asserted requests.
  always_comb begin
    gnt_valid = |req;
    gnt       = PORT_CPU;
`ifdef SRAM_ARB_RR_EN
    if (&req) begin
      gnt = ~last;
    end else if (req[1]) begin
      gnt = PORT_AUX;
    end
`else
    if (!req[0] && req[1]) begin
      gnt = PORT_AUX;
    end
`endif
  end

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Shares one SRAM controller port between a CPU requester
//               (port 0) and a secondary master (port 1). One transaction in
//               flight; IDLE -> BUSY -> DONE with a bus-hang watchdog that
//               aborts an access after TIMEOUT BUSY cycles (0 disables it).
//               Build option SRAM_ARB_RR_EN selects round-robin arbitration
//               instead of fixed CPU priority.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int AW      = 18,
  parameter int DW      = 16,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          rq0_req,
  input  logic          rq0_we,
  input  logic [AW-1:0] rq0_addr,
  input  logic [DW-1:0] rq0_wdata,
  output logic          rq0_ack,
  output logic [DW-1:0] rq0_rdata,
  output logic          rq0_err,
  input  logic          rq1_req,
  input  logic          rq1_we,
  input  logic [AW-1:0] rq1_addr,
  input  logic [DW-1:0] rq1_wdata,
  output logic          rq1_ack,
  output logic [DW-1:0] rq1_rdata,
  output logic          rq1_err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  // Counter must hold TIMEOUT without wrapping; saturates at all-ones.
  localparam int WDW = $clog2(TIMEOUT + 2);

  state_e          state_q, state_d;
  logic            win_q, win_d;
  logic            we_q, we_d;
  logic            err_q, err_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata0_q, rdata0_d;
  logic [DW-1:0]   rdata1_q, rdata1_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic [WDW-1:0]  wd_inc;
  logic            last;
  logic            gnt;
  logic            gnt_valid;

`ifdef SRAM_ARB_RR_EN
  logic last_q, last_d;
  assign last = last_q;
`else
  assign last = 1'b0;
`endif

  sram_arb_pick u_pick (
    .req       ({rq1_req, rq0_req}),
    .last      (last),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );

  assign wd_inc = wd_q + 1'b1;

  // Next-state, transaction capture, watchdog and read-data return.
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    we_d     = we_q;
    err_d    = err_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    wd_d     = wd_q;
`ifdef SRAM_ARB_RR_EN
    last_d   = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          win_d   = gnt;
          we_d    = (gnt == PORT_AUX) ? rq1_we    : rq0_we;
          addr_d  = (gnt == PORT_AUX) ? rq1_addr  : rq0_addr;
          wdata_d = (gnt == PORT_AUX) ? rq1_wdata : rq0_wdata;
          err_d   = 1'b0;
          wd_d    = '0;
          state_d = ST_BUSY;
`ifdef SRAM_ARB_RR_EN
          last_d  = gnt;
`endif
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          if (!we_q) begin
            if (win_q == PORT_AUX) rdata1_d = mem_rdata;
            else                   rdata0_d = mem_rdata;
          end
          state_d = ST_DONE;
        end else if ((TIMEOUT != 0) && (wd_inc == WDW'(TIMEOUT))) begin
          // This was the TIMEOUT-th BUSY cycle without completion: abort.
          if (!we_q) begin
            if (win_q == PORT_AUX) rdata1_d = DW'(RDATA_ABORT);
            else                   rdata0_d = DW'(RDATA_ABORT);
          end
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (wd_q != '1) begin
          wd_d = wd_inc;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops the strobes immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      win_q    <= PORT_CPU;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      wd_q     <= '0;
`ifdef SRAM_ARB_RR_EN
      last_q   <= PORT_CPU;
`endif
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      we_q     <= we_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      wd_q     <= wd_d;
`ifdef SRAM_ARB_RR_EN
      last_q   <= last_d;
`endif
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_read  = (state_q == ST_BUSY) && !we_q;
  assign mem_write = (state_q == ST_BUSY) &&  we_q;

  // DONE doubles as the strobe-free turnaround cycle and the ack cycle.
  assign rq0_ack   = (state_q == ST_DONE) && (win_q == PORT_CPU);
  assign rq1_ack   = (state_q == ST_DONE) && (win_q == PORT_AUX);
  assign rq0_err   = rq0_ack && err_q;
  assign rq1_err   = rq1_ack && err_q;
  assign rq0_rdata = rdata0_q;
  assign rq1_rdata = rdata1_q;

endmodule
`default_nettype wire
